// File: rtl/tone_audio_if.sv
// Control and DAC-side signal bundle for tone_audio_tx.
// The master drives the tone controls; the slave (the transmitter) drives the DAC pins.
interface tone_audio_if;
  logic [31:0] toneL;
  logic [31:0] toneR;
  logic [2:0]  volume;
  logic        mute;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_sck;
  logic        audio_sdin;
  logic        frame_start;

  modport master (
    output toneL, toneR, volume, mute,
    input  audio_mclk, audio_lrck, audio_sck, audio_sdin, frame_start
  );

  modport slave (
    input  toneL, toneR, volume, mute,
    output audio_mclk, audio_lrck, audio_sck, audio_sdin, frame_start
  );
endinterface

// File: rtl/tone_audio_tx.sv
// Two-channel square-wave tone generator that serialises 16-bit stereo samples
// in left-justified format, with all DAC clocks derived from one 512-clk frame divider.
module tone_audio_tx #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned MAX_TONE = 20_000
) (
  input  logic        clk,
  input  logic        rst,
  tone_audio_if.slave bus
);

  localparam logic [27:0] CLK_C = 28'(CLK_HZ);
  localparam logic [31:0] MAX_C = 32'(MAX_TONE);

  logic [8:0]  cnt_q, cnt_d;
  logic [31:0] tone_l_q, tone_r_q;
  logic [2:0]  vol_q;
  logic        mute_q;
  logic [26:0] acc_l_q, acc_l_d;
  logic [26:0] acc_r_q, acc_r_d;
  logic        pol_l_q, pol_l_d;
  logic        pol_r_q, pol_r_d;
  logic [31:0] shift_q, shift_d;
  logic        mclk_q, lrck_q, sck_q, frame_q;
  logic [15:0] left_smp, right_smp;

  function automatic logic audible(input logic [31:0] tone);
    return (tone != 32'd0) && (tone <= MAX_C);
  endfunction

  // Returns {pol, acc}; a wrap of the accumulator past CLK_HZ flips the polarity,
  // which yields a square wave of exactly the requested frequency.
  function automatic logic [27:0] phase_next(input logic [26:0] acc,
                                             input logic        pol,
                                             input logic [31:0] tone);
    logic [27:0] sum;
    logic [27:0] res;
    sum = {1'b0, acc} + {tone[26:0], 1'b0};
    if (!audible(tone)) begin
      res = 28'd0;
    end else if (sum >= CLK_C) begin
      res = {~pol, 27'(sum - CLK_C)};
    end else begin
      res = {pol, sum[26:0]};
    end
    return res;
  endfunction

  function automatic logic [15:0] sample_of(input logic       pol,
                                            input logic       aud,
                                            input logic [2:0] vol,
                                            input logic       mte);
    logic [15:0] amp;
    logic [15:0] res;
    amp = {1'b0, vol, 12'h000};
    if (!aud || (vol == 3'd0) || mte) begin
      res = 16'h0000;
    end else if (pol) begin
      res = amp;
    end else begin
      res = 16'h0000 - amp;
    end
    return res;
  endfunction

  // Next-state: divider, both phase accumulators, sample build and frame shifter.
  always_comb begin
    cnt_d              = cnt_q + 9'd1;
    {pol_l_d, acc_l_d} = phase_next(acc_l_q, pol_l_q, tone_l_q);
    {pol_r_d, acc_r_d} = phase_next(acc_r_q, pol_r_q, tone_r_q);
    left_smp           = sample_of(pol_l_q, audible(tone_l_q), vol_q, mute_q);
    right_smp          = sample_of(pol_r_q, audible(tone_r_q), vol_q, mute_q);
    // The skipped shift at 511 leaves the last bit on the wire until the reload.
    if (cnt_q == 9'd0) begin
      shift_d = {left_smp, right_smp};
    end else if ((cnt_q[3:0] == 4'hF) && (cnt_q != 9'd511)) begin
      shift_d = {shift_q[30:0], 1'b0};
    end else begin
      shift_d = shift_q;
    end
  end

  // State and registered DAC outputs; everything clears asynchronously on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= 9'd0;
      tone_l_q <= 32'd0;
      tone_r_q <= 32'd0;
      vol_q    <= 3'd0;
      mute_q   <= 1'b0;
      acc_l_q  <= 27'd0;
      acc_r_q  <= 27'd0;
      pol_l_q  <= 1'b0;
      pol_r_q  <= 1'b0;
      shift_q  <= 32'd0;
      mclk_q   <= 1'b0;
      lrck_q   <= 1'b0;
      sck_q    <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tone_l_q <= bus.toneL;
      tone_r_q <= bus.toneR;
      vol_q    <= bus.volume;
      mute_q   <= bus.mute;
      acc_l_q  <= acc_l_d;
      acc_r_q  <= acc_r_d;
      pol_l_q  <= pol_l_d;
      pol_r_q  <= pol_r_d;
      shift_q  <= shift_d;
      mclk_q   <= cnt_q[1];
      lrck_q   <= cnt_q[8];
      sck_q    <= cnt_q[3];
      frame_q  <= (cnt_q == 9'd0);
    end
  end

  assign bus.audio_mclk  = mclk_q;
  assign bus.audio_lrck  = lrck_q;
  assign bus.audio_sck   = sck_q;
  assign bus.audio_sdin  = shift_q[31];
  assign bus.frame_start = frame_q;

endmodule

// File: tb/tb_tone_audio_tx.sv
// Randomised bench for tone_audio_tx, checked against a total-phase reference model.
module tb_tone_audio_tx;
  localparam longint CLK_T = 1_000_000;
  localparam longint MAX_T = 20_000;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  tone_audio_if aif();

  tone_audio_tx #(.CLK_HZ(1_000_000), .MAX_TONE(20_000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (aif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each channel tracks the total phase advanced since it last went silent;
  // acc = total mod CLK, polarity = parity of floor(total / CLK).
  longint      tot_l, tot_r;
  logic [31:0] lat_tl, lat_tr;
  logic [2:0]  lat_v;
  logic        lat_m;
  int          mcnt;
  logic [31:0] exp_word_m;

  function automatic logic m_aud(input logic [31:0] t);
    return (t != 32'd0) && (longint'(t) <= MAX_T);
  endfunction

  function automatic logic [15:0] m_sample(input longint tot, input logic [31:0] t,
                                           input logic [2:0] v, input logic m);
    int amp;
    if (!m_aud(t) || v == 3'd0 || m) return 16'h0000;
    amp = int'(v) * 4096;
    if (((tot / CLK_T) % 2) == 1) return 16'(amp);
    return 16'(65536 - amp);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tot_l = 0; tot_r = 0; lat_tl = 32'd0; lat_tr = 32'd0;
      lat_v = 3'd0; lat_m = 1'b0; mcnt = 0; exp_word_m = 32'd0;
    end else begin
      if (mcnt == 0)
        exp_word_m = {m_sample(tot_l, lat_tl, lat_v, lat_m), m_sample(tot_r, lat_tr, lat_v, lat_m)};
      tot_l  = m_aud(lat_tl) ? tot_l + 2 * longint'(lat_tl) : 0;
      tot_r  = m_aud(lat_tr) ? tot_r + 2 * longint'(lat_tr) : 0;
      lat_tl = aif.toneL;
      lat_tr = aif.toneR;
      lat_v  = aif.volume;
      lat_m  = aif.mute;
      mcnt   = (mcnt + 1) % 512;
    end
  end

  // Waits for frame_start, then checks the DAC clocks every cycle of the frame and
  // collects sdin at each sck rising edge. act_kind 1 sets mute, 2 retunes left to 294 Hz.
  task automatic capture_frame(input int act_off, input int act_kind,
                               output logic [31:0] word, output logic [31:0] expw);
    int          waited;
    logic [8:0]  ov;
    logic [3:0]  got_c, exp_c;
    waited = 0;
    word   = 32'd0;
    expw   = 32'd0;
    while (aif.frame_start !== 1'b1) begin
      if (waited > 600) begin
        total++; bad++;
        $display("FAIL frame_start_timeout: waited %0d clk, required pulse within 512", waited);
        return;
      end
      @(posedge clk); #1;
      waited++;
    end
    expw = exp_word_m;
    for (int o = 0; o < 512; o++) begin
      if (o > 0) begin @(posedge clk); #1; end
      ov    = 9'(o);
      exp_c = {ov[1], ov[3], ov[8], (ov == 9'd0)};
      got_c = {aif.audio_mclk, aif.audio_sck, aif.audio_lrck, aif.frame_start};
      total++;
      if (got_c !== exp_c) begin
        bad++;
        $display("FAIL clocks at offset %0d: got mclk/sck/lrck/fs=%b required %b", o, got_c, exp_c);
      end
      if (ov[3:0] == 4'd8) word[31 - o / 16] = aif.audio_sdin;
      if (o == act_off && act_kind == 1) aif.mute = 1'b1;
      if (o == act_off && act_kind == 2) aif.toneL = 32'd294;
    end
  endtask

  task automatic wait_toggle(output int n);
    logic p0;
    n  = 0;
    p0 = dut.pol_l_q;
    while (dut.pol_l_q === p0 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_acc(input string name);
    total++;
    if (dut.acc_l_q !== 27'(tot_l % CLK_T) || dut.pol_l_q !== 1'((tot_l / CLK_T) % 2)) begin
      bad++;
      $display("FAIL %s left phase: got acc=%0d pol=%0d required acc=%0d pol=%0d", name,
               dut.acc_l_q, dut.pol_l_q, tot_l % CLK_T, (tot_l / CLK_T) % 2);
    end
    total++;
    if (dut.acc_r_q !== 27'(tot_r % CLK_T) || dut.pol_r_q !== 1'((tot_r / CLK_T) % 2)) begin
      bad++;
      $display("FAIL %s right phase: got acc=%0d pol=%0d required acc=%0d pol=%0d", name,
               dut.acc_r_q, dut.pol_r_q, tot_r % CLK_T, (tot_r / CLK_T) % 2);
    end
  endtask

  task automatic test_reset();
    logic [31:0] w, e;
    logic [4:0]  outs;
    rst = 1'b0;
    aif.toneL = 32'd0; aif.toneR = 32'd0; aif.volume = 3'd0; aif.mute = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    outs = {aif.audio_mclk, aif.audio_lrck, aif.audio_sck, aif.audio_sdin, aif.frame_start};
    total++;
    if (outs !== 5'b00000) begin
      bad++; $display("FAIL reset_outputs: got %b required 00000", outs);
    end
    total++;
    if (dut.cnt_q !== 9'd0 || dut.shift_q !== 32'd0) begin
      bad++; $display("FAIL reset_state: got cnt=%0d shift=%h required 0", dut.cnt_q, dut.shift_q);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (aif.frame_start !== 1'b1) begin
      bad++; $display("FAIL first_frame_start: got %b required 1", aif.frame_start);
    end
    for (int f = 0; f < 2; f++) begin
      capture_frame(-1, 0, w, e);
      total++;
      if (w !== 32'd0 || e !== 32'd0) begin
        bad++; $display("FAIL idle_sdin: got %h model %h required 00000000", w, e);
      end
    end
  endtask

  task automatic test_tone();
    logic [31:0] w, e;
    int n0, n1;
    aif.toneL  = 32'd440;
    aif.toneR  = 32'($urandom_range(100, 20000));
    aif.volume = 3'd7;
    aif.mute   = 1'b0;
    for (int f = 0; f < 5; f++) begin
      capture_frame(-1, 0, w, e);
      total++;
      if (w !== e) begin
        bad++; $display("FAIL tone_frame %0d: got %h required %h", f, w, e);
      end
      if (f > 0) begin
        total++;
        if (w[31:16] !== 16'h7000 && w[31:16] !== 16'h9000) begin
          bad++; $display("FAIL tone_left_amp: got %h required 7000 or 9000", w[31:16]);
        end
      end
    end
    check_acc("tone");
    wait_toggle(n0);
    wait_toggle(n1);
    total++;
    if (n1 != 1136 && n1 != 1137) begin
      bad++; $display("FAIL tone_440_interval: got %0d clk required 1136 or 1137", n1);
    end
  endtask

  task automatic test_silence();
    logic [31:0] w, e;
    aif.toneL  = 32'($urandom_range(20, 20000));
    aif.toneR  = 32'd50_000_000;
    aif.volume = 3'd7;
    for (int f = 0; f < 3; f++) begin
      capture_frame(-1, 0, w, e);
      total++;
      if (w !== e || w[15:0] !== 16'h0000) begin
        bad++; $display("FAIL silence_frame %0d: got %h required %h with right 0000", f, w, e);
      end
      total++;
      if (dut.acc_r_q !== 27'd0) begin
        bad++; $display("FAIL silence_acc_r: got %0d required 0", dut.acc_r_q);
      end
    end
    check_acc("silence");
  endtask

  task automatic test_random();
    logic [31:0] w, e;
    logic [31:0] t [2];
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 2; c++) begin
        case ($urandom_range(0, 4))
          0:       t[c] = 32'd0;
          1:       t[c] = 32'($urandom_range(20001, 900000));
          default: t[c] = 32'($urandom_range(20, 20000));
        endcase
      end
      aif.toneL  = t[0];
      aif.toneR  = t[1];
      aif.volume = 3'($urandom_range(0, 7));
      aif.mute   = ($urandom_range(0, 3) == 0);
      for (int f = 0; f < 2; f++) begin
        capture_frame(-1, 0, w, e);
        total++;
        if (w !== e) begin
          bad++; $display("FAIL random_frame %0d.%0d: got %h required %h", k, f, w, e);
        end
      end
      check_acc("random");
    end
  endtask

  task automatic test_mute();
    logic [31:0] w, e;
    aif.toneL = 32'd262; aif.toneR = 32'd330; aif.volume = 3'd3; aif.mute = 1'b0;
    capture_frame(-1, 0, w, e);
    capture_frame(200, 1, w, e);
    total++;
    if (w !== e || (w[31:16] !== 16'h3000 && w[31:16] !== 16'hD000) ||
        (w[15:0] !== 16'h3000 && w[15:0] !== 16'hD000)) begin
      bad++; $display("FAIL mute_inflight: got %h required %h (halves 3000/D000)", w, e);
    end
    for (int f = 0; f < 2; f++) begin
      capture_frame(-1, 0, w, e);
      total++;
      if (w !== 32'd0) begin
        bad++; $display("FAIL mute_after %0d: got %h required 00000000", f, w);
      end
    end
    aif.mute = 1'b0;
  endtask

  task automatic test_tone_change();
    logic [31:0] w, e;
    int n0, n1;
    aif.toneL = 32'd262; aif.toneR = 32'd0; aif.volume = 3'd5; aif.mute = 1'b0;
    capture_frame(-1, 0, w, e);
    capture_frame(100, 2, w, e);
    total++;
    if (w !== e) begin
      bad++; $display("FAIL change_inflight: got %h required %h", w, e);
    end
    check_acc("change");
    wait_toggle(n0);
    wait_toggle(n1);
    total++;
    if (n1 != 1700 && n1 != 1701) begin
      bad++; $display("FAIL tone_294_interval: got %0d clk required 1700 or 1701", n1);
    end
    check_acc("change_later");
  endtask

  task automatic test_reset_mid();
    logic [31:0] w, e;
    logic [4:0]  outs;
    aif.toneL = 32'd440; aif.toneR = 32'd0; aif.volume = 3'd7; aif.mute = 1'b0;
    capture_frame(-1, 0, w, e);
    capture_frame(300, 0, w, e);
    @(posedge clk); #1;
    while (aif.frame_start !== 1'b1 && mcnt < 600) begin @(posedge clk); #1; end
    repeat (300) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    outs = {aif.audio_mclk, aif.audio_lrck, aif.audio_sck, aif.audio_sdin, aif.frame_start};
    total++;
    if (outs !== 5'b00000 || dut.acc_l_q !== 27'd0 || dut.cnt_q !== 9'd0) begin
      bad++; $display("FAIL midreset_clear: got outs=%b acc=%0d cnt=%0d required 0", outs,
                      dut.acc_l_q, dut.cnt_q);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (aif.frame_start !== 1'b1) begin
      bad++; $display("FAIL midreset_restart: got frame_start=%b required 1", aif.frame_start);
    end
    capture_frame(-1, 0, w, e);
    total++;
    if (w !== 32'd0 || e !== 32'd0) begin
      bad++; $display("FAIL midreset_zero_frame: got %h model %h required 00000000", w, e);
    end
    capture_frame(-1, 0, w, e);
    total++;
    if (w !== e) begin
      bad++; $display("FAIL midreset_resume: got %h required %h", w, e);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    test_reset();
    test_tone();
    test_silence();
    test_random();
    test_mute();
    test_tone_change();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
